// File: rtl/ram_port_arbiter.sv
// Purpose : round-robin arbiter sharing a dual-port RAM between N_REQ requesters, up to two grants per cycle.
// Latency : gnt is combinational in cycle T, RAM command registered at end of T, read data returned in T+2.
// Backpressure: a requester holds req until gnt; losers and suppressed same-address B winners simply retry.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req/req_we                  per-requester request and write flag
//   req_addr/req_wdata          packed per-requester address / write data (slice i = requester i)
//   gnt                         combinational one-cycle grant pulse (at most two bits set)
//   rvalid/rdata                read-return strobe and data (slice i), data is 0 when not valid
//   ram_we/addr/data_a/b        registered RAM command for port A / port B
//   ram_val_a/b                 RAM read values (registered inside the RAM)
module ram_port_arbiter #(
    parameter int N_REQ = 4,
    parameter int AW    = 6,
    parameter int DW    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_we,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [N_REQ*DW-1:0] rdata,
    output logic                ram_we_a,
    output logic                ram_we_b,
    output logic [AW-1:0]       ram_addr_a,
    output logic [AW-1:0]       ram_addr_b,
    output logic [DW-1:0]       ram_data_a,
    output logic [DW-1:0]       ram_data_b,
    input  logic [DW-1:0]       ram_val_a,
    input  logic [DW-1:0]       ram_val_b
);

    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] scan_idx;
    logic [PW-1:0] a_idx;
    logic [PW-1:0] b_idx;
    logic          a_found;
    logic          b_found;
    logic          b_conflict;
    logic          b_gnt;

    logic [AW-1:0] addr_arr  [N_REQ];
    logic [DW-1:0] wdata_arr [N_REQ];

    // Read tags: stage 1 loads at grant, stage 2 lines up with the RAM output register.
    logic          tag_a1_vld, tag_a2_vld, tag_b1_vld, tag_b2_vld;
    logic [PW-1:0] tag_a1_id,  tag_a2_id,  tag_b1_id,  tag_b2_id;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*AW +: AW];
        assign wdata_arr[g] = req_wdata[g*DW +: DW];
    end

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        return (v == PW'(N_REQ - 1)) ? '0 : v + PW'(1);
    endfunction

    // One circular scan from ptr: the first hit is A, the second hit is B.
    // Everything between ptr and A is idle, so the second hit equals a
    // circular search starting at A+1 that excludes A.
    always_comb begin
        a_found  = 1'b0;
        b_found  = 1'b0;
        a_idx    = '0;
        b_idx    = '0;
        scan_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = PW'((int'(ptr) + k) % N_REQ);
            if (req[scan_idx]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx   = scan_idx;
                end else if (!b_found) begin
                    b_found = 1'b1;
                    b_idx   = scan_idx;
                end
            end
        end
    end

    // A same-address pair involving a write would race inside the RAM, so B
    // waits a cycle; no later requester is promoted into its slot.
    always_comb begin
        b_conflict = b_found
                  && (addr_arr[a_idx] == addr_arr[b_idx])
                  && (req_we[a_idx] || req_we[b_idx]);
        b_gnt      = b_found && !b_conflict;
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i] = rst_n && ((a_found && (a_idx == PW'(i))) ||
                               (b_gnt   && (b_idx == PW'(i))));
        end
    end

    always_comb begin
        ptr_nxt = ptr;
        if (b_gnt) begin
            ptr_nxt = wrap_inc(b_idx);
        end else if (a_found) begin
            ptr_nxt = wrap_inc(a_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            ram_we_a   <= 1'b0;
            ram_addr_a <= '0;
            ram_data_a <= '0;
            ram_we_b   <= 1'b0;
            ram_addr_b <= '0;
            ram_data_b <= '0;
            tag_a1_vld <= 1'b0;
            tag_a1_id  <= '0;
            tag_a2_vld <= 1'b0;
            tag_a2_id  <= '0;
            tag_b1_vld <= 1'b0;
            tag_b1_id  <= '0;
            tag_b2_vld <= 1'b0;
            tag_b2_id  <= '0;
        end else begin
            ptr        <= ptr_nxt;
            // Idle ports issue a harmless read of address 0 whose data is ignored.
            ram_we_a   <= a_found && req_we[a_idx];
            ram_addr_a <= a_found ? addr_arr[a_idx]  : '0;
            ram_data_a <= a_found ? wdata_arr[a_idx] : '0;
            ram_we_b   <= b_gnt && req_we[b_idx];
            ram_addr_b <= b_gnt ? addr_arr[b_idx]  : '0;
            ram_data_b <= b_gnt ? wdata_arr[b_idx] : '0;
            tag_a1_vld <= a_found && !req_we[a_idx];
            tag_a1_id  <= a_idx;
            tag_b1_vld <= b_gnt && !req_we[b_idx];
            tag_b1_id  <= b_idx;
            tag_a2_vld <= tag_a1_vld;
            tag_a2_id  <= tag_a1_id;
            tag_b2_vld <= tag_b1_vld;
            tag_b2_id  <= tag_b1_id;
        end
    end

    // A requester is granted at most once per cycle, so the two ports never
    // target the same return slot.
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (tag_a2_vld && (tag_a2_id == PW'(i))) begin
                rvalid[i]          = 1'b1;
                rdata[i*DW +: DW]  = ram_val_a;
            end
            if (tag_b2_vld && (tag_b2_id == PW'(i))) begin
                rvalid[i]          = 1'b1;
                rdata[i*DW +: DW]  = ram_val_b;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [N*DW-1:0] rdata;
    logic            ram_we_a, ram_we_b;
    logic [AW-1:0]   ram_addr_a, ram_addr_b;
    logic [DW-1:0]   ram_data_a, ram_data_b;
    logic [DW-1:0]   ram_val_a, ram_val_b;

    ram_port_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .ram_we_a   (ram_we_a),
        .ram_we_b   (ram_we_b),
        .ram_addr_a (ram_addr_a),
        .ram_addr_b (ram_addr_b),
        .ram_data_a (ram_data_a),
        .ram_data_b (ram_data_b),
        .ram_val_a  (ram_val_a),
        .ram_val_b  (ram_val_b)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM with registered read data.
    logic [DW-1:0] mem [64];
    logic          preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
            mem[3]    <= 8'h11;
            mem[7]    <= 8'h22;
            preloaded <= 1'b1;
        end else begin
            if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
            if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
        end
        ram_val_a <= mem[ram_addr_a];
        ram_val_b <= mem[ram_addr_b];
    end

    typedef struct {
        int            cyc;
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] sh [64];
    logic [AW-1:0] a_arr [N];
    logic [DW-1:0] d_arr [N];
    logic [N-1:0]  we_v;
    int            gcnt [N];
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: every cycle the full rvalid/rdata vectors must match
    // exactly the returns scheduled for this cycle (zero otherwise).
    always @(negedge clk) begin
        logic [N-1:0]    exp_v;
        logic [N*DW-1:0] exp_d;
        exp_v = '0;
        exp_d = '0;
        for (int k = q.size() - 1; k >= 0; k--) begin
            if (q[k].cyc == cyc) begin
                exp_v[q[k].id]            = 1'b1;
                exp_d[q[k].id*DW +: DW]   = q[k].data;
                q.delete(k);
            end
        end
        chk("rvalid", 32'(rvalid), 32'(exp_v));
        chk("rdata",  32'(rdata),  32'(exp_d));
    end

    // One directed cycle: drive after the edge, check gnt mid-cycle, then
    // schedule expected read returns and update the shadow memory.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] exp_g,
                        input string tag, input bit rel = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        if (rel) rst_n = 1'b1;
        req    = r;
        req_we = we_v;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = a_arr[i];
            req_wdata[i*DW +: DW] = d_arr[i];
        end
        @(negedge clk);
        chk(tag, 32'(gnt), 32'(exp_g));
        for (int i = 0; i < N; i++) gcnt[i] += int'(gnt[i]);
        for (int i = 0; i < N; i++) begin
            if (exp_g[i] && !we_v[i]) begin
                e.cyc  = cyc + 2;
                e.id   = i;
                e.data = sh[a_arr[i]];
                q.push_back(e);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (exp_g[i] && we_v[i]) sh[a_arr[i]] = d_arr[i];
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, '0, "idle");
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) sh[i] = '0;
        sh[3] = 8'h11;
        sh[7] = 8'h22;
        for (int i = 0; i < N; i++) begin
            a_arr[i] = '0;
            d_arr[i] = '0;
            gcnt[i]  = 0;
        end
        we_v      = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req       = '0;
        rst_n     = 1'b1;
        #1;
        // Reset held with every requester asking
        rst_n = 1'b0;
        req   = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt",    32'(gnt),        32'h0);
        chk("rst_we_a",   32'(ram_we_a),   32'h0);
        chk("rst_we_b",   32'(ram_we_b),   32'h0);
        chk("rst_addr_a", 32'(ram_addr_a), 32'h0);
        step(4'b1111, 4'b0011, "first_after_rst", 1'b1);
        idle(3);

        // Write then read of the same address by requester 2
        do_reset();
        we_v[2] = 1'b1; a_arr[2] = 6'h15; d_arr[2] = 8'hA5;
        step(4'b0100, 4'b0100, "wr_gnt");
        we_v[2] = 1'b0;
        step(4'b0100, 4'b0100, "rd_gnt");
        chk("cmd_we_a",   32'(ram_we_a),   32'h1);
        chk("cmd_addr_a", 32'(ram_addr_a), 32'h15);
        chk("cmd_data_a", 32'(ram_data_a), 32'hA5);
        idle(3);

        // Dual read in one cycle, then show ptr wrapped back to 0
        do_reset();
        a_arr[0] = 6'd3; a_arr[3] = 6'd7; a_arr[1] = 6'd1; a_arr[2] = 6'd2;
        step(4'b1001, 4'b1001, "dual_gnt");
        step(4'b1111, 4'b0011, "dual_ptr");
        step(4'b1100, 4'b1100, "dual_rest");
        idle(3);

        // Same-address write/read conflict with ptr = 1
        do_reset();
        a_arr[0] = 6'd0;
        step(4'b0001, 4'b0001, "conf_setptr");
        we_v[1] = 1'b1; a_arr[1] = 6'd9; d_arr[1] = 8'h5A;
        a_arr[2] = 6'd9;
        step(4'b0110, 4'b0010, "conf_t0");
        we_v[1] = 1'b0;
        step(4'b0100, 4'b0100, "conf_t1");
        idle(3);

        // Fairness under continuous load
        do_reset();
        for (int i = 0; i < N; i++) begin
            a_arr[i] = AW'(i + 3);
            gcnt[i]  = 0;
        end
        for (int k = 0; k < 8; k++) step(4'b1111, (k % 2 == 0) ? 4'b0011 : 4'b1100, "fair_gnt");
        idle(3);
        for (int i = 0; i < N; i++) chk($sformatf("fair_cnt%0d", i), 32'(gcnt[i]), 32'd4);

        // Reset during an in-flight read
        do_reset();
        a_arr[0] = 6'd7;
        step(4'b0001, 4'b0001, "mid_t0");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req   = '0;
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b1111, 4'b0011, "mid_ptr");
        idle(4);

        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares the 64 x 8-bit dual-port RAM between N_REQ independent requesters. Each cycle it grants up to two requests: the first winner is issued on RAM port A and the second on port B. It registers the RAM command signals and returns read data to the originating requester with a fixed latency. The block sits directly in front of `dual_port_ram`, and every requester in the subsystem reaches the RAM only through it.

## Interface
- N_REQ, 4, number of requesters (2..8)
- AW, 6, RAM address width
- DW, 8, RAM data width
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  N_REQ  request per requester; held until granted
- req_we  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*AW  address, slice i belongs to requester i
- req_wdata  in  N_REQ*DW  write data, slice i
- gnt  out  N_REQ  combinational, one-cycle grant pulse
- rvalid  out  N_REQ  read-return strobe
- rdata  out  N_REQ*DW  read data, slice i; valid only when rvalid[i] is high, otherwise 0
- ram_we_a, ram_we_b  out  1  registered RAM write enables
- ram_addr_a, ram_addr_b  out  AW  registered RAM addresses
- ram_data_a, ram_data_b  out  DW  registered RAM write data
- ram_val_a, ram_val_b  in  DW  RAM read values (registered inside the RAM)

## Operation
- Requester rules:
  - While req[i]=1 and gnt[i]=0, req_we, req_addr and req_wdata for slice i must stay stable.
  - req[i] is dropped, or a new request is presented, in the cycle after gnt[i].
- State: round-robin pointer ptr, width clog2(N_REQ), reset to 0.
- Winner A: the first i with req[i]=1, searching circularly from ptr.
- Winner B: the next i with req[i]=1, searching circularly from A+1 and excluding A.
  - B is suppressed if addr(B)==addr(A) and either of the two is a write.
  - B is never replaced by a later requester when it is suppressed; it retries next cycle.
- gnt is asserted for A and, if not suppressed, for B. At most two bits of gnt are high.
- Pointer update:
  - If only A is granted, ptr <= A+1 mod N_REQ.
  - If A and B are granted, ptr <= B+1 mod N_REQ.
  - If no request is granted, ptr holds.
- RAM command registers, loaded every cycle:
  - Granted port: we, addr and data take the winner's values.
  - Idle port: we=0, addr=0, data=0. The resulting idle read of address 0 is discarded.
- Read tag pipeline, per port:
  - Stage 1: {valid, id}, loaded at grant.
  - Stage 2: copy of stage 1.
  - A valid stage-2 tag on port A sets rvalid[id]=1 and rdata slice id = ram_val_a. Port B works the same way with ram_val_b.
- Writes produce no rvalid.

## Timing
- Cycle T: gnt pulses; it depends combinationally on req, req_we, req_addr and ptr.
- Edge ending T: ram_* registers load.
- Cycle T+1: RAM sees the command. The write or read happens at the edge ending T+1.
- Read return: cycle T+2, rvalid[i] and rdata valid for exactly one cycle. Latency is 2 cycles from the gnt cycle.
- Throughput: 2 accesses per cycle, fully pipelined, no bubbles.
- Ordering:
  - Write granted in T, then read of the same address granted in T+1: the read returns the new data.
  - Two reads of the same address in the same cycle are both granted and return identical data.
- Reset, asynchronous assert:
  - ptr=0.
  - All ram_we/addr/data=0.
  - All tags invalid.
  - gnt=0 while rst_n=0.
  - rvalid=0 and rdata=0.
- Reset mid-operation: in-flight reads are dropped with no rvalid. A write already presented to the RAM before reset asserted is not rolled back.
- First grant is possible in the first cycle with rst_n=1.

## Test plan
- Reset: drive req=4'b1111 with rst_n=0 -> gnt=0, ram_we_a/b=0, rvalid=0, rdata=0. After release, the first cycle grants requesters 0 and 1.
- Write then read:
  - Requester 2 writes 0xA5 to addr 0x15 (gnt in T0), then reads addr 0x15 (gnt in T1).
  - Required: rvalid[2]=1 in T3 with rdata slice 2 = 0xA5. No rvalid in T2.
- Dual read:
  - RAM preloaded with addr 3 = 0x11 and addr 7 = 0x22. Requester 0 reads 3 and requester 3 reads 7 in the same cycle.
  - Required: both gnt bits in T0; rvalid[0] (0x11) and rvalid[3] (0x22) in T2; ptr = 0 afterwards.
- Conflict:
  - Requester 1 writes 0x5A to addr 9 and requester 2 reads addr 9, with ptr=1.
  - Required: T0 gnt=4'b0010 only; T1 gnt=4'b0100; the read returns 0x5A in T3.
- Fairness: all 4 requesters issue continuous reads for 8 cycles -> the grant pairs are {0,1},{2,3},{0,1}..., and each requester gets exactly 4 grants.
- Reset mid-read: assert rst_n=0 in T1 after a read granted in T0 -> no rvalid in T2 or afterwards, and ptr returns to 0.
